// File: rtl/imm_extend_stage.sv
// Registered immediate generator: opcode picks sign/zero/upper/branch extension, result one cycle after accept.
// Backpressure: one-entry skid behind the output register; InReady drops only while the skid is occupied.
module imm_extend_stage #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int SHAMT     = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [IN_WIDTH-1:0]  Imm,
  input  logic [5:0]           Opcode,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [OUT_WIDTH-1:0] OutData,
  output logic [1:0]           OutMode
);

  localparam logic [1:0] MODE_SIGN   = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  logic [1:0]                 mode_dec;
  logic signed [OUT_WIDTH-1:0] sext;
  logic [OUT_WIDTH-1:0]       zext;
  logic [OUT_WIDTH-1:0]       ext_data;

  logic                 out_valid;
  logic                 skid_valid;
  logic [OUT_WIDTH-1:0] skid_data;
  logic [1:0]           skid_mode;
  logic                 accept;

  always_comb begin
    mode_dec = MODE_SIGN;
    case (Opcode)
      6'h0C, 6'h0D, 6'h0E:               mode_dec = MODE_ZERO;
      6'h0F:                             mode_dec = MODE_UPPER;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: mode_dec = MODE_BRANCH;
      default:                           mode_dec = MODE_SIGN;
    endcase
  end

  // Casts rather than replication so OUT_WIDTH == IN_WIDTH stays legal.
  assign sext = OUT_WIDTH'($signed(Imm));
  assign zext = OUT_WIDTH'(Imm);

  always_comb begin
    ext_data = sext;
    case (mode_dec)
      MODE_ZERO:   ext_data = zext;
      MODE_UPPER:  ext_data = zext << (OUT_WIDTH - IN_WIDTH);
      MODE_BRANCH: ext_data = sext << SHAMT;
      default:     ext_data = sext;
    endcase
  end

  assign InReady  = !skid_valid;
  assign OutValid = out_valid;
  assign accept   = InValid && !skid_valid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      OutData    <= '0;
      OutMode    <= MODE_SIGN;
      skid_data  <= '0;
      skid_mode  <= MODE_SIGN;
    end else if (Flush) begin
      // Payload registers are left as-is; OutValid already qualifies them.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || OutReady) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        OutData    <= skid_data;
        OutMode    <= skid_mode;
        skid_valid <= accept;
        if (accept) begin
          skid_data <= ext_data;
          skid_mode <= mode_dec;
        end
      end else begin
        out_valid <= accept;
        if (accept) begin
          OutData <= ext_data;
          OutMode <= mode_dec;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
      skid_mode  <= mode_dec;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboarded random + directed bench for imm_extend_stage, plus a re-parametrised instance.
module tb_imm_extend_stage;

  logic        Clk = 1'b0;
  logic        Reset, Flush, InValid, OutReady;
  logic        InReady, OutValid;
  logic [15:0] Imm;
  logic [5:0]  Opcode;
  logic [31:0] OutData;
  logic [1:0]  OutMode;

  logic        b_reset, b_flush, b_invalid, b_outready;
  logic        b_inready, b_outvalid;
  logic [11:0] b_imm;
  logic [5:0]  b_opcode;
  logic [31:0] b_outdata;
  logic [1:0]  b_outmode;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] expq[$];

  always #5 Clk = ~Clk;

  imm_extend_stage dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Imm(Imm), .Opcode(Opcode), .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .OutMode(OutMode)
  );

  imm_extend_stage #(.IN_WIDTH(12), .OUT_WIDTH(32), .SHAMT(1)) dut_b (
    .Clk(Clk), .Reset(b_reset), .Flush(b_flush), .InValid(b_invalid), .InReady(b_inready),
    .Imm(b_imm), .Opcode(b_opcode), .OutValid(b_outvalid), .OutReady(b_outready),
    .OutData(b_outdata), .OutMode(b_outmode)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: value arithmetic on the immediate, returns {mode, data}.
  function automatic logic [33:0] model(input longint imm, input logic [5:0] op,
                                        input int in_w, input int out_w, input int sh);
    logic [1:0] mode;
    longint v;
    if (op inside {6'h0C, 6'h0D, 6'h0E}) mode = 2'd1;
    else if (op == 6'h0F) mode = 2'd2;
    else if (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) mode = 2'd3;
    else mode = 2'd0;
    v = imm;
    if ((mode == 2'd0 || mode == 2'd3) && ((imm >> (in_w - 1)) & 1) == 1)
      v = imm - (longint'(1) << in_w);
    if (mode == 2'd2) v = imm * (longint'(1) << (out_w - in_w));
    if (mode == 2'd3) v = v * (longint'(1) << sh);
    v = v & ((longint'(1) << out_w) - 1);
    return {mode, v[31:0]};
  endfunction

  // Issue side: record every accepted input.
  always @(negedge Clk) begin
    if (!Reset && !Flush && InValid && InReady)
      expq.push_back(model(longint'(Imm), Opcode, 16, 32, 2));
  end

  // Monitor: pop on each output handshake, check stability while stalled.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_mode;
  always @(negedge Clk) begin
    logic [33:0] e;
    if (Reset || Flush) begin
      expq.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_valid", 64'(OutValid), 64'd1);
        chk("stall_hold", {30'd0, OutMode, OutData}, {30'd0, prev_mode, prev_data});
      end
      if (OutValid && OutReady) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", {30'd0, OutMode, OutData}, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          e = expq.pop_front();
          chk("scoreboard", {30'd0, OutMode, OutData}, {30'd0, e});
        end
      end
      prev_hold = OutValid && !OutReady;
      prev_data = OutData;
      prev_mode = OutMode;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] imm, input logic [5:0] op);
    InValid = 1'b1;
    Imm     = imm;
    Opcode  = op;
  endtask

  localparam logic [5:0] OPS [13] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h01, 6'h04,
                                      6'h05, 6'h06, 6'h07, 6'h23, 6'h00, 6'h3F};

  initial begin
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0; Imm = '0; Opcode = '0;
    b_reset = 1'b1; b_flush = 1'b0; b_invalid = 1'b0; b_outready = 1'b1; b_imm = '0; b_opcode = '0;
    cyc(2);
    Reset = 1'b0; b_reset = 1'b0;
    chk("reset_outvalid", 64'(OutValid), 64'd0);
    chk("reset_outdata", 64'(OutData), 64'd0);
    chk("reset_outmode", 64'(OutMode), 64'd0);
    chk("reset_inready", 64'(InReady), 64'd1);

    // Single addi
    OutReady = 1'b1;
    drive(16'h8004, 6'h08);
    cyc();
    InValid = 1'b0;
    chk("addi_valid", 64'(OutValid), 64'd1);
    chk("addi_data", {30'd0, OutMode, OutData}, {30'd0, 2'd0, 32'hFFFF8004});
    cyc();

    // Back-to-back ori, lui, beq
    drive(16'h8004, 6'h0D); cyc();
    drive(16'h1234, 6'h0F);
    chk("ori", {30'd0, OutMode, OutData}, {30'd0, 2'd1, 32'h00008004});
    cyc();
    drive(16'hFFFF, 6'h04);
    chk("lui", {30'd0, OutMode, OutData}, {30'd0, 2'd2, 32'h12340000});
    cyc();
    InValid = 1'b0;
    chk("beq", {30'd0, OutMode, OutData}, {30'd0, 2'd3, 32'hFFFFFFFC});
    cyc();

    // Stall fills output register then skid
    OutReady = 1'b0;
    drive(16'h0001, 6'h08); cyc();
    drive(16'h0002, 6'h08); cyc();
    InValid = 1'b0;
    chk("stall_inready", 64'(InReady), 64'd0);
    chk("stall_data1", 64'(OutData), 64'h1);
    OutReady = 1'b1;
    cyc();
    chk("drain_data2", 64'(OutData), 64'h2);
    chk("drain_inready", 64'(InReady), 64'd1);
    cyc();
    chk("drain_idle", 64'(OutValid), 64'd0);

    // Flush with both entries full and an incoming input
    OutReady = 1'b0;
    drive(16'h0011, 6'h08); cyc();
    drive(16'h0022, 6'h0C); cyc();
    drive(16'h0033, 6'h0F);
    chk("preflush_full", {62'd0, OutValid, InReady}, {62'd0, 1'b1, 1'b0});
    Flush = 1'b1;
    cyc();
    Flush = 1'b0; InValid = 1'b0;
    chk("flush_outvalid", 64'(OutValid), 64'd0);
    chk("flush_inready", 64'(InReady), 64'd1);
    OutReady = 1'b1;
    cyc(5);
    chk("flush_no_output", 64'(OutValid), 64'd0);

    // Reset mid-stall
    OutReady = 1'b0;
    drive(16'h7777, 6'h08); cyc();
    drive(16'h1111, 6'h0D); cyc();
    InValid = 1'b0;
    Reset = 1'b1; cyc(); Reset = 1'b0;
    chk("rst_mid_outvalid", 64'(OutValid), 64'd0);
    chk("rst_mid_outdata", 64'(OutData), 64'd0);
    chk("rst_mid_inready", 64'(InReady), 64'd1);

    // Randomised traffic with occasional flush
    for (int i = 0; i < 600; i++) begin
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 2) != 0);
      Imm      = 16'($urandom);
      Opcode   = ($urandom_range(0, 4) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 12)];
      Flush    = ($urandom_range(0, 59) == 0);
      cyc();
    end
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    for (int i = 0; i < 10 && (expq.size() != 0 || OutValid); i++) cyc();
    chk("final_queue_empty", 64'(expq.size()), 64'd0);
    chk("final_idle", 64'(OutValid), 64'd0);

    // Re-parametrised instance: IN_WIDTH=12, SHAMT=1
    b_invalid = 1'b1; b_imm = 12'h800; b_opcode = 6'h04;
    cyc();
    b_opcode = 6'h08;
    chk("p12_branch", {30'd0, b_outmode, b_outdata}, {30'd0, 2'd3, 32'hFFFFF000});
    cyc();
    b_invalid = 1'b0;
    chk("p12_addi", {30'd0, b_outmode, b_outdata}, {30'd0, 2'd0, 32'hFFFFF800});
    for (int i = 0; i < 20; i++) begin
      logic [11:0] r;
      logic [5:0]  op;
      r  = 12'($urandom);
      op = OPS[$urandom_range(0, 12)];
      b_invalid = 1'b1; b_imm = r; b_opcode = op;
      cyc();
      b_invalid = 1'b0;
      chk("p12_random", {30'd0, b_outmode, b_outdata}, {30'd0, model(longint'(r), op, 12, 32, 1)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
